// File: rtl/fht_ctrl_pkg.sv
// Shared definitions for the radix-4 FHT core: controller states and the
// transform-size derivations used by the sequencer, butterfly and RAM wrappers.
package fht_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_SWAP,
    ST_DONE
  } fht_state_t;

  localparam int FHT_N_DEFAULT = 1024;

  function automatic int clog4(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 4;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int fht_n_bank(input int n);
    return n / 4;
  endfunction

  function automatic int fht_a_bit(input int n);
    return $clog2(n / 4);
  endfunction

  function automatic int fht_stages(input int n);
    return clog4(n);
  endfunction

endpackage

// File: rtl/fht_delay_line.sv
// Fixed-depth shift register that turns the read strobe/address into the
// write strobe/address once the butterfly pipeline has produced its result.
module fht_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             iCLK,
  input  logic             iCLR,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // old value, which is what makes this a shift register and not a wire.
  // NOTE: this array is cleared on purpose: a reset must flush pending writes
  // so no stale write enable escapes into the RAM banks.
  always_ff @(posedge iCLK) begin
    if (iCLR) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= iD;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign oQ = pipe_q[DEPTH-1];

endmodule

// File: rtl/fht_stage_ctrl.sv
// Stage sequencer for the radix-4 FHT: walks every butterfly stage over the
// ping-pong banks, producing read/twiddle/write addressing and the ADC grant.
module fht_stage_ctrl
  import fht_ctrl_pkg::*;
#(
  parameter int N      = FHT_N_DEFAULT,
  parameter int BF_LAT = 4
) (
  input  logic                        iCLK,
  input  logic                        iRESET,
  input  logic                        iSTART,
  output logic                        oBUSY,
  output logic                        oRDY,
  output logic [2:0]                  oSTAGE,
  output logic                        oRAM_SEL,
  output logic                        oRD_EN,
  output logic [fht_a_bit(N)-1:0]     oADDR_RD,
  output logic [fht_a_bit(N)-1:0]     oTW_IDX,
  output logic                        oWE,
  output logic [fht_a_bit(N)-1:0]     oADDR_WR,
  output logic                        oEXT_GRANT
);

  localparam int N_BANK = fht_n_bank(N);
  localparam int A_BIT  = fht_a_bit(N);
  localparam int STAGES = fht_stages(N);
  localparam int D_W    = $clog2(BF_LAT + 1);

  fht_state_t       state_q, state_d;
  logic [A_BIT-1:0] cnt_q, cnt_d;
  logic [D_W-1:0]   drain_q, drain_d;
  logic [2:0]       stage_q, stage_d;
  logic             sel_q, sel_d;
  logic             rd_en_q, rd_en_d;
  logic [A_BIT-1:0] addr_rd_q, addr_rd_d;
  logic [A_BIT-1:0] tw_q, tw_d;
  logic             busy_q, rdy_q, grant_q;

  // Twiddle index = (cnt mod 4^s) scaled up to the full-length ROM spacing.
  function automatic logic [A_BIT-1:0] tw_index(input logic [A_BIT-1:0] c,
                                                input logic [2:0]       s);
    logic [A_BIT:0] lim;
    lim = (A_BIT+1)'(1) << (2 * s);
    return (c & A_BIT'(lim - (A_BIT+1)'(1))) << (2 * (STAGES - 1 - int'(s)));
  endfunction

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis would infer latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    stage_d = stage_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: if (iSTART) begin
        state_d = ST_READ;
        cnt_d   = '0;
        stage_d = '0;
        sel_d   = 1'b0;
      end
      ST_READ: begin
        cnt_d = cnt_q + A_BIT'(1);
        if (cnt_q == A_BIT'(N_BANK - 1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + D_W'(1);
        if (drain_q == D_W'(BF_LAT - 1)) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        // The final swap flips too, so the read side ends up on the result bank.
        sel_d = ~sel_q;
        if (stage_q == 3'(STAGES - 1)) begin
          state_d = ST_DONE;
        end else begin
          stage_d = stage_q + 3'd1;
          cnt_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rd_en_d   = (state_d == ST_READ);
    addr_rd_d = rd_en_d ? cnt_d : '0;
    tw_d      = rd_en_d ? tw_index(cnt_d, stage_d) : '0;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      drain_q   <= '0;
      stage_q   <= '0;
      sel_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_rd_q <= '0;
      tw_q      <= '0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      grant_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      stage_q   <= stage_d;
      sel_q     <= sel_d;
      rd_en_q   <= rd_en_d;
      addr_rd_q <= addr_rd_d;
      tw_q      <= tw_d;
      busy_q    <= (state_d != ST_IDLE);
      rdy_q     <= (state_d == ST_DONE);
      grant_q   <= (state_d == ST_IDLE);
    end
  end

  fht_delay_line #(
    .WIDTH(A_BIT + 1),
    .DEPTH(BF_LAT)
  ) u_wr_delay (
    .iCLK(iCLK),
    .iCLR(iRESET),
    .iD  ({rd_en_q, addr_rd_q}),
    .oQ  ({oWE, oADDR_WR})
  );

  assign oBUSY      = busy_q;
  assign oRDY       = rdy_q;
  assign oSTAGE     = stage_q;
  assign oRAM_SEL   = sel_q;
  assign oRD_EN     = rd_en_q;
  assign oADDR_RD   = addr_rd_q;
  assign oTW_IDX    = tw_q;
  assign oEXT_GRANT = grant_q;

endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Self-checking bench for fht_stage_ctrl: cycle model of the control outputs,
// write-path scoreboard, twiddle vector table and start/reset corner sequences.
module tb_fht_stage_ctrl;

  localparam int N       = 1024;
  localparam int BF_LAT  = 4;
  localparam int N_BANK  = 256;
  localparam int STAGES  = 5;
  localparam int PERIOD  = N_BANK + BF_LAT + 1;
  localparam int DONE_T  = STAGES * PERIOD + 1;
  localparam int NV      = 8;

  logic       clk;
  logic       iRESET, iSTART;
  logic       oBUSY, oRDY, oRAM_SEL, oRD_EN, oWE, oEXT_GRANT;
  logic [2:0] oSTAGE;
  logic [7:0] oADDR_RD, oTW_IDX, oADDR_WR;

  fht_stage_ctrl #(.N(N), .BF_LAT(BF_LAT)) dut (
    .iCLK(clk), .iRESET(iRESET), .iSTART(iSTART),
    .oBUSY(oBUSY), .oRDY(oRDY), .oSTAGE(oSTAGE), .oRAM_SEL(oRAM_SEL),
    .oRD_EN(oRD_EN), .oADDR_RD(oADDR_RD), .oTW_IDX(oTW_IDX),
    .oWE(oWE), .oADDR_WR(oADDR_WR), .oEXT_GRANT(oEXT_GRANT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       rdy;
    logic       grant;
    logic       sel;
    logic       rd_en;
    logic [2:0] stage;
    logic [7:0] addr;
    logic [7:0] tw;
  } ctl_t;

  typedef struct {
    int addr;
    int due;
  } wr_t;

  typedef struct {
    int stage;
    int cnt;
    int tw;
  } tw_vec_t;

  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      n_rd = 0, n_we = 0, n_rdy = 0, rdy_cyc = -1;
  wr_t     sb[$];
  tw_vec_t tv[NV];

  bit m_active = 1'b0;
  int m_t = 0;
  int m_stage = 0;
  bit m_sel = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: inputs held since the previous negedge are taken by the DUT at
  // the posedge; the model advances and all outputs are compared at the negedge.
  task automatic step();
    bit   s_rst, s_start;
    int   p, r;
    ctl_t e, a;
    wr_t  item;
    logic exp_we;
    int   exp_wa;
    s_rst   = iRESET;
    s_start = iSTART;
    @(negedge clk);
    cyc++;

    if (s_rst) begin
      m_active = 1'b0;
      m_stage  = 0;
      m_sel    = 1'b0;
      sb.delete();
    end else if (m_active) begin
      m_t++;
      if (m_t > DONE_T) m_active = 1'b0;
    end else if (s_start) begin
      m_active = 1'b1;
      m_t      = 1;
    end

    e = '0;
    e.grant = 1'b1;
    if (m_active) begin
      e.busy  = 1'b1;
      e.grant = 1'b0;
      if (m_t == DONE_T) begin
        e.rdy   = 1'b1;
        m_stage = STAGES - 1;
        m_sel   = (STAGES % 2) == 1;
      end else begin
        p = (m_t - 1) / PERIOD;
        r = (m_t - 1) % PERIOD;
        m_stage = p;
        m_sel   = (p % 2) == 1;
        if (r < N_BANK) begin
          e.rd_en = 1'b1;
          e.addr  = 8'(r);
          e.tw    = 8'((r % (4 ** p)) * (4 ** (STAGES - 1 - p)));
          sb.push_back('{addr: r, due: cyc + BF_LAT});
        end
      end
    end
    e.stage = 3'(m_stage);
    e.sel   = m_sel;

    a = {oBUSY, oRDY, oEXT_GRANT, oRAM_SEL, oRD_EN, oSTAGE, oADDR_RD, oTW_IDX};
    check("ctl", 32'(a), 32'(e));

    exp_we = 1'b0;
    exp_wa = 0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      item   = sb.pop_front();
      exp_we = 1'b1;
      exp_wa = item.addr;
    end
    check("wr", {23'b0, oWE, (oWE === 1'b1) ? oADDR_WR : 8'h00},
                {23'b0, exp_we, 8'(exp_wa)});

    if (oRD_EN === 1'b1) n_rd++;
    if (oWE === 1'b1) n_we++;
    if (oRDY === 1'b1) begin
      n_rdy++;
      rdy_cyc = cyc;
    end
  endtask

  // Drives start at cycle s, spurious starts at p0..p2, reset at rst_at
  // (-1 = never) and steps until cycle stop_at.
  task automatic run_seq(input int s, input int p0, input int p1, input int p2,
                         input int rst_at, input int stop_at, input bit use_tab);
    int ti;
    ti = 0;
    while (cyc < stop_at) begin
      iSTART = (cyc == s || cyc == p0 || cyc == p1 || cyc == p2);
      iRESET = (cyc == rst_at);
      step();
      if (use_tab && ti < NV &&
          cyc == s + 1 + tv[ti].stage * PERIOD + tv[ti].cnt) begin
        check("tw_stage", 32'(oSTAGE), 32'(tv[ti].stage));
        check("tw_addr", 32'(oADDR_RD), 32'(tv[ti].cnt));
        check("tw_idx", 32'(oTW_IDX), 32'(tv[ti].tw));
        ti++;
      end
    end
    iSTART = 1'b0;
    iRESET = 1'b0;
  endtask

  task automatic check_run(input string tag, input int s, input int rd0,
                           input int we0, input int rdy0);
    check({tag, "_rdy_count"}, 32'(n_rdy - rdy0), 32'd1);
    check({tag, "_rdy_cycle"}, 32'(rdy_cyc), 32'(s + DONE_T));
    check({tag, "_rd_cycles"}, 32'(n_rd - rd0), 32'(STAGES * N_BANK));
    check({tag, "_we_cycles"}, 32'(n_we - we0), 32'(STAGES * N_BANK));
    check({tag, "_ram_sel"}, 32'(oRAM_SEL), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int s, rd0, we0, rdy0;
    tv[0] = '{stage: 0, cnt: 0,   tw: 0};
    tv[1] = '{stage: 0, cnt: 255, tw: 0};
    tv[2] = '{stage: 1, cnt: 7,   tw: 192};
    tv[3] = '{stage: 2, cnt: 37,  tw: 80};
    tv[4] = '{stage: 3, cnt: 63,  tw: 252};
    tv[5] = '{stage: 3, cnt: 200, tw: 32};
    tv[6] = '{stage: 4, cnt: 200, tw: 200};
    tv[7] = '{stage: 4, cnt: 255, tw: 255};

    iRESET = 1'b1;
    iSTART = 1'b0;
    repeat (3) step();
    iRESET = 1'b0;
    check("rst_rd_en", 32'(oRD_EN), 32'd0);
    check("rst_we", 32'(oWE), 32'd0);
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_rdy", 32'(oRDY), 32'd0);
    check("rst_grant", 32'(oEXT_GRANT), 32'd1);
    check("rst_stage", 32'(oSTAGE), 32'd0);
    check("rst_sel", 32'(oRAM_SEL), 32'd0);
    check("rst_addr_wr", 32'(oADDR_WR), 32'd0);

    // Full run, start pulse at cycle 10.
    rd0 = n_rd; we0 = n_we; rdy0 = n_rdy;
    run_seq(10, -1, -1, -1, -1, 10 + DONE_T + 5, 1'b1);
    check_run("run1", 10, rd0, we0, rdy0);
    check("run1_final_stage", 32'(oSTAGE), 32'(STAGES - 1));

    // Start pulses in stage 2, in DRAIN and in DONE must all be ignored.
    s = cyc + 3;
    rd0 = n_rd; we0 = n_we; rdy0 = n_rdy;
    run_seq(s, s + 1 + 2 * PERIOD + 50, s + 1 + 3 * PERIOD + N_BANK + 1,
            s + DONE_T, -1, s + DONE_T + 10, 1'b0);
    check_run("run2", s, rd0, we0, rdy0);
    check("run2_idle_busy", 32'(oBUSY), 32'd0);

    // Reset in the second DRAIN cycle of stage 3.
    s = cyc + 2;
    run_seq(s, -1, -1, -1, s + 1 + 3 * PERIOD + N_BANK + 1,
            s + 1 + 3 * PERIOD + N_BANK + 2, 1'b0);
    check("mid_rst_we", 32'(oWE), 32'd0);
    check("mid_rst_busy", 32'(oBUSY), 32'd0);
    check("mid_rst_grant", 32'(oEXT_GRANT), 32'd1);
    check("mid_rst_rd_en", 32'(oRD_EN), 32'd0);
    we0 = n_we;
    run_seq(-1, -1, -1, -1, -1, cyc + 20, 1'b0);
    check("mid_rst_no_writes", 32'(n_we - we0), 32'd0);

    // Fresh start after the aborted run.
    s = cyc + 2;
    rd0 = n_rd; we0 = n_we; rdy0 = n_rdy;
    run_seq(s, -1, -1, -1, -1, s + DONE_T + 5, 1'b0);
    check_run("run4", s, rd0, we0, rdy0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
